// File: rtl/ct_fcnvt_vec_seq.sv
// Vector element sequencer for the scalar fcnvt pipe: issues one element per cycle,
// packs the ex3 returns into a 128-bit destination and reports one completion.
module ct_fcnvt_vec_seq #(
    parameter int PIPE_LAT = 3,
    parameter int VLEN     = 128
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            rtu_yy_xx_flush,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic [VLEN-1:0] req_src,
    input  logic [1:0]      req_sew,
    input  logic [3:0]      req_vl,
    input  logic [19:0]     req_func,
    output logic            seq_ex1_vld,
    output logic [63:0]     seq_ex1_src,
    output logic [19:0]     seq_ex1_func,
    input  logic            fcnvt_ex3_vld,
    input  logic [63:0]     fcnvt_ex3_result,
    input  logic [4:0]      fcnvt_ex3_expt,
    output logic            seq_done_vld,
    output logic [VLEN-1:0] seq_done_result,
    output logic [4:0]      seq_done_fflags
);

    localparam int CNT_W = $clog2(PIPE_LAT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_FLUSHW = 3'd4;

    // Clamp the requested length to the number of lanes that fit in VLEN.
    function automatic logic [3:0] eff_vl(input logic [1:0] sew, input logic [3:0] vl);
        logic [3:0] vlmax;
        case (sew)
            2'd0:    vlmax = 4'd8;
            2'd1:    vlmax = 4'd4;
            default: vlmax = 4'd2;
        endcase
        return (vl > vlmax) ? vlmax : vl;
    endfunction

    function automatic logic [63:0] get_elem(input logic [VLEN-1:0] src, input logic [1:0] sew,
                                             input logic [2:0] idx);
        logic [63:0] e;
        e = '0;
        case (sew)
            2'd0:    e[15:0] = src[{idx[2:0], 4'b0} +: 16];
            2'd1:    e[31:0] = src[{idx[1:0], 5'b0} +: 32];
            default: e       = src[{idx[0], 6'b0} +: 64];
        endcase
        return e;
    endfunction

    function automatic logic [VLEN-1:0] put_lane(input logic [VLEN-1:0] acc, input logic [1:0] sew,
                                                 input logic [2:0] idx, input logic [63:0] res);
        logic [VLEN-1:0] r;
        r = acc;
        case (sew)
            2'd0:    r[{idx[2:0], 4'b0} +: 16] = res[15:0];
            2'd1:    r[{idx[1:0], 5'b0} +: 32] = res[31:0];
            default: r[{idx[0], 6'b0} +: 64]   = res;
        endcase
        return r;
    endfunction

    logic [2:0]      state;
    logic [VLEN-1:0] src_q;
    logic [VLEN-1:0] result_q;
    logic [1:0]      sew_q;
    logic [19:0]     func_q;
    logic [3:0]      vl_q;
    logic [3:0]      iss_cnt;
    logic [3:0]      ret_cnt;
    logic [4:0]      fflags_q;
    logic [CNT_W-1:0] flw_cnt;

    logic            busy;
    logic            flush_hit;
    logic            ret_take;
    logic            last_iss;
    logic [3:0]      ret_cnt_nxt;
    logic [3:0]      acc_vl;

    assign busy        = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_DONE);
    assign flush_hit   = rtu_yy_xx_flush && (busy || (state == S_FLUSHW));
    assign ret_take    = fcnvt_ex3_vld && ((state == S_ISSUE) || (state == S_DRAIN)) && (ret_cnt < vl_q);
    assign ret_cnt_nxt = ret_cnt + {3'b0, ret_take};
    assign last_iss    = (iss_cnt == (vl_q - 4'd1));
    assign acc_vl      = eff_vl(req_sew, req_vl);

    // Issue and completion are gated by flush in the same cycle so nothing escapes.
    assign req_rdy         = (state == S_IDLE);
    assign seq_ex1_vld     = (state == S_ISSUE) && !rtu_yy_xx_flush;
    assign seq_ex1_src     = seq_ex1_vld ? get_elem(src_q, sew_q, iss_cnt[2:0]) : '0;
    assign seq_ex1_func    = func_q;
    assign seq_done_vld    = (state == S_DONE) && !rtu_yy_xx_flush;
    assign seq_done_result = result_q;
    assign seq_done_fflags = fflags_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= S_IDLE;
            src_q    <= '0;
            result_q <= '0;
            sew_q    <= '0;
            func_q   <= '0;
            vl_q     <= '0;
            iss_cnt  <= '0;
            ret_cnt  <= '0;
            fflags_q <= '0;
            flw_cnt  <= '0;
        end else if (flush_hit) begin
            state   <= S_FLUSHW;
            flw_cnt <= CNT_W'(PIPE_LAT - 1);
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_vld) begin
                        src_q    <= req_src;
                        sew_q    <= req_sew;
                        func_q   <= req_func;
                        vl_q     <= acc_vl;
                        iss_cnt  <= '0;
                        ret_cnt  <= '0;
                        result_q <= '0;
                        fflags_q <= '0;
                        state    <= (acc_vl == 4'd0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    iss_cnt <= iss_cnt + 4'd1;
                    if (last_iss) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ret_cnt_nxt == vl_q) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                S_FLUSHW: begin
                    if (flw_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        flw_cnt <= flw_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Returns only arrive in ISSUE/DRAIN, so they never collide with the IDLE latch.
            if (ret_take) begin
                result_q <= put_lane(result_q, sew_q, ret_cnt[2:0], fcnvt_ex3_result);
                fflags_q <= fflags_q | fcnvt_ex3_expt;
                ret_cnt  <= ret_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ct_fcnvt_vec_seq.sv
// Self-checking bench for ct_fcnvt_vec_seq: the bench plays the 3-stage fcnvt pipe and
// predicts issue windows, completion timing and packed results from request-level rules.
module tb_ct_fcnvt_vec_seq;

    localparam int          PIPE_LAT = 3;
    localparam logic [63:0] KRES     = 64'hABCD_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         req_vld = 1'b0;
    logic         req_rdy;
    logic [127:0] req_src = '0;
    logic [1:0]   req_sew = '0;
    logic [3:0]   req_vl = '0;
    logic [19:0]  req_func = '0;
    logic         seq_ex1_vld;
    logic [63:0]  seq_ex1_src;
    logic [19:0]  seq_ex1_func;
    logic         ex3_vld = 1'b0;
    logic [63:0]  ex3_result = '0;
    logic [4:0]   ex3_expt = '0;
    logic         seq_done_vld;
    logic [127:0] seq_done_result;
    logic [4:0]   seq_done_fflags;

    ct_fcnvt_vec_seq dut (
        .forever_cpuclk  (clk),
        .cpurst_b        (rst_n),
        .rtu_yy_xx_flush (flush),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_src         (req_src),
        .req_sew         (req_sew),
        .req_vl          (req_vl),
        .req_func        (req_func),
        .seq_ex1_vld     (seq_ex1_vld),
        .seq_ex1_src     (seq_ex1_src),
        .seq_ex1_func    (seq_ex1_func),
        .fcnvt_ex3_vld   (ex3_vld),
        .fcnvt_ex3_result(ex3_result),
        .fcnvt_ex3_expt  (ex3_expt),
        .seq_done_vld    (seq_done_vld),
        .seq_done_result (seq_done_result),
        .seq_done_fflags (seq_done_fflags)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Request-level model state
    int           cyc = 0;
    int           busy_end = -1;
    int           iss_lo = 0;
    int           iss_hi = -1;
    int           done_at = -1;
    int           acc_cyc = 0;
    int           done_cyc = 0;
    int           iss_seen = 0;
    int           done_seen = 0;
    logic [127:0] m_src = '0;
    logic [1:0]   m_sew = '0;
    logic [19:0]  m_func = '0;
    logic [127:0] exp_res = '0;
    logic [4:0]   exp_ff = '0;
    logic [4:0]   ex_tab [8];

    // Bench-side fcnvt pipe: issue captured in cycle n returns in cycle n+3
    logic        dl_v [3];
    logic [63:0] dl_s [3];
    logic [4:0]  dl_e [3];
    logic        cur_v = 1'b0;
    logic [63:0] cur_s = '0;
    logic [4:0]  cur_e = '0;

    function automatic int lane_w(input logic [1:0] sew);
        return (sew == 2'd0) ? 16 : (sew == 2'd1) ? 32 : 64;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] sew);
        int w;
        w = lane_w(sew);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] elem_of(input logic [127:0] s, input logic [1:0] sew, input int i);
        logic [127:0] sh;
        sh = s >> (i * lane_w(sew));
        return sh[63:0] & lane_mask(sew);
    endfunction

    function automatic int evl_of(input logic [1:0] sew, input logic [3:0] vl);
        int vmax;
        vmax = 128 / lane_w(sew);
        return (int'(vl) > vmax) ? vmax : int'(vl);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        busy_end = -1;
        iss_hi   = -1;
        done_at  = -1;
        cur_v    = 1'b0;
        for (int i = 0; i < 3; i++) dl_v[i] = 1'b0;
    endtask

    // One clock cycle: drive the pipe and the request/flush inputs, then check all outputs.
    task automatic step(input logic rv, input logic fl);
        logic exp_rdy;
        logic exp_v;
        int   evl;
        @(posedge clk);
        #1;
        cyc++;
        dl_v[2] = dl_v[1]; dl_s[2] = dl_s[1]; dl_e[2] = dl_e[1];
        dl_v[1] = dl_v[0]; dl_s[1] = dl_s[0]; dl_e[1] = dl_e[0];
        dl_v[0] = cur_v;   dl_s[0] = cur_s;   dl_e[0] = cur_e;
        ex3_vld    = dl_v[2];
        ex3_result = dl_v[2] ? (dl_s[2] + 64'd1 + KRES) : {$urandom, $urandom};
        ex3_expt   = dl_v[2] ? dl_e[2] : 5'($urandom);
        req_vld    = rv;
        flush      = fl;

        exp_rdy = (cyc > busy_end);
        if (fl && !exp_rdy) begin
            busy_end = cyc + PIPE_LAT;
            if (iss_hi >= cyc) iss_hi = cyc - 1;
            done_at = -1;
        end else if (rv && exp_rdy && !fl) begin
            evl     = evl_of(req_sew, req_vl);
            m_src   = req_src;
            m_sew   = req_sew;
            m_func  = req_func;
            acc_cyc = cyc;
            iss_lo  = cyc + 1;
            iss_hi  = cyc + evl;
            done_at = (evl == 0) ? cyc + 1 : cyc + evl + PIPE_LAT + 1;
            busy_end = done_at;
            exp_res = '0;
            exp_ff  = '0;
            for (int i = 0; i < evl; i++) begin
                exp_res |= {64'b0, (elem_of(req_src, req_sew, i) + 64'd1 + KRES) & lane_mask(req_sew)}
                           << (i * lane_w(req_sew));
                exp_ff  |= ex_tab[i];
            end
        end

        #4;
        exp_v = (cyc >= iss_lo) && (cyc <= iss_hi);
        chk("req_rdy", 128'(req_rdy), 128'(exp_rdy));
        chk("ex1_vld", 128'(seq_ex1_vld), 128'(exp_v));
        if (exp_v) begin
            chk("ex1_src", 128'(seq_ex1_src), 128'(elem_of(m_src, m_sew, cyc - iss_lo)));
            chk("ex1_func", 128'(seq_ex1_func), 128'(m_func));
        end
        chk("done_vld", 128'(seq_done_vld), 128'(cyc == done_at));
        if (cyc == done_at) begin
            chk("done_result", seq_done_result, exp_res);
            chk("done_fflags", 128'(seq_done_fflags), 128'(exp_ff));
            done_cyc = cyc;
        end
        if (seq_ex1_vld) iss_seen++;
        if (seq_done_vld) done_seen++;
        cur_v = seq_ex1_vld;
        cur_s = seq_ex1_src;
        cur_e = ex_tab[(cyc - iss_lo) & 7];
    endtask

    task automatic launch(input logic [127:0] s, input logic [1:0] sew, input logic [3:0] vl,
                          input logic [19:0] fn);
        req_src  = s;
        req_sew  = sew;
        req_vl   = vl;
        req_func = fn;
        iss_seen = 0;
        done_seen = 0;
        step(1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        int fl_at;
        logic do_fl;
        logic dbl;
        for (int i = 0; i < 8; i++) ex_tab[i] = '0;
        model_reset();

        // Reset values
        #3;
        chk("rst_req_rdy", 128'(req_rdy), 128'(1'b1));
        chk("rst_ex1_vld", 128'(seq_ex1_vld), 128'(1'b0));
        chk("rst_done_vld", 128'(seq_done_vld), 128'(1'b0));
        chk("rst_result", seq_done_result, 128'd0);
        chk("rst_fflags", 128'(seq_done_fflags), 128'd0);
        chk("rst_ex1_src", 128'(seq_ex1_src), 128'd0);
        chk("rst_ex1_func", 128'(seq_ex1_func), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Four singles, results element+1, no exceptions
        launch({32'd4, 32'd3, 32'd2, 32'd1}, 2'd1, 4'd4, 20'h12345);
        idle(10);
        chk("t1_result_lit", seq_done_result, 128'h00000005_00000004_00000003_00000002);
        chk("t1_fflags_lit", 128'(seq_done_fflags), 128'd0);
        chk("t1_latency", 128'(done_cyc - acc_cyc), 128'd8);
        chk("t1_issues", 128'(iss_seen), 128'd4);
        chk("t1_dones", 128'(done_seen), 128'd1);

        // Eight halves with flags on elements 2 and 6
        ex_tab[2] = 5'b00001;
        ex_tab[6] = 5'b00100;
        launch(128'h0008_0007_0006_0005_0004_0003_0002_0001, 2'd0, 4'd8, 20'h0ABCD);
        idle(14);
        chk("t2_fflags_lit", 128'(seq_done_fflags), 128'(5'b00101));
        chk("t2_result_lit", seq_done_result, 128'h0009_0008_0007_0006_0005_0004_0003_0002);
        chk("t2_issues", 128'(iss_seen), 128'd8);
        for (int i = 0; i < 8; i++) ex_tab[i] = '0;

        // Doubles, vl clamped from 5 to 2
        launch({64'h2222_0000_0000_0010, 64'h1111_0000_0000_0020}, 2'd2, 4'd5, 20'h00001);
        idle(10);
        chk("t3_issues", 128'(iss_seen), 128'd2);
        chk("t3_result_lit", seq_done_result,
            {64'h2222_0000_0000_0011 + KRES, 64'h1111_0000_0000_0021 + KRES});

        // vl=0: immediate completion, empty result
        launch({4{32'hDEAD_BEEF}}, 2'd1, 4'd0, 20'h0);
        idle(4);
        chk("t4_latency", 128'(done_cyc - acc_cyc), 128'd1);
        chk("t4_issues", 128'(iss_seen), 128'd0);
        chk("t4_result_lit", seq_done_result, 128'd0);

        // Flush in DRAIN with two returns still outstanding; stale flags must not leak
        for (int i = 0; i < 8; i++) ex_tab[i] = 5'h1F;
        launch({32'h40, 32'h30, 32'h20, 32'h10}, 2'd1, 4'd4, 20'h00777);
        idle(4);
        step(1'b0, 1'b1);
        idle(6);
        chk("t5_no_done", 128'(done_seen), 128'd0);
        for (int i = 0; i < 8; i++) ex_tab[i] = '0;
        launch({32'h4, 32'h3, 32'h2, 32'h1}, 2'd1, 4'd3, 20'h00888);
        idle(10);
        chk("t5_next_result_lit", seq_done_result, 128'h00000000_00000004_00000003_00000002);
        chk("t5_next_fflags_lit", 128'(seq_done_fflags), 128'd0);

        // Randomized requests with occasional (double) flushes
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 8; i++) ex_tab[i] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            do_fl = ($urandom_range(0, 3) == 0);
            dbl   = ($urandom_range(0, 1) == 0);
            fl_at = $urandom_range(1, 12);
            launch({$urandom, $urandom, $urandom, $urandom}, 2'($urandom), 4'($urandom), 20'($urandom));
            for (int k = 1; k <= 20; k++) step(1'b0, do_fl && (k == fl_at || (dbl && k == fl_at + 2)));
        end

        // Asynchronous reset in the middle of ISSUE
        launch(128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 2'd0, 4'd8, 20'h00055);
        idle(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ex1_vld", 128'(seq_ex1_vld), 128'(1'b0));
        chk("rst_mid_req_rdy", 128'(req_rdy), 128'(1'b1));
        chk("rst_mid_result", seq_done_result, 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        idle(2);
        launch({32'h7, 32'h6, 32'h5, 32'h4}, 2'd1, 4'd2, 20'h00066);
        idle(8);
        chk("post_rst_result_lit", seq_done_result, 128'h00000000_00000000_00000006_00000005);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ct_fcnvt_vec_seq.md
Name: ct_fcnvt_vec_seq

Overview:
- Element sequencer in front of the scalar fcnvt pipe (ex1→ex3, 3 stages).
- Accepts one 128-bit vector convert request and issues its elements to the pipe one per cycle.
- Collects the ex3 results and packs them into a 128-bit destination, OR-accumulating the 5-bit exception flags.
- Returns one completion to the vfalu pipe, and supports flush with drain protection.

Parameters:
- PIPE_LAT, 3, cycles from seq_ex1_vld to matching fcnvt_ex3_vld; also the length of the post-flush quiet window.
- VLEN, 128, destination vector width in bits; fixed at 128, vl width 4 derives from it.

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- rtu_yy_xx_flush  in  1  pipeline flush
- req_vld  in  1  request valid
- req_rdy  out  1  sequencer can accept a request
- req_src  in  128  packed source elements
- req_sew  in  2  element width: 0=16b, 1=32b, 2=64b, 3=reserved (treated as 64b)
- req_vl  in  4  active element count
- req_func  in  20  convert function code, passed through
- seq_ex1_vld  out  1  element issued to ex1 (drives ex1 pipedown)
- seq_ex1_src  out  64  current element, zero-extended
- seq_ex1_func  out  20  latched func
- fcnvt_ex3_vld  in  1  ex3 result valid
- fcnvt_ex3_result  in  64  element result
- fcnvt_ex3_expt  in  5  element exception flags
- seq_done_vld  out  1  completion pulse
- seq_done_result  out  128  packed result
- seq_done_fflags  out  5  OR of all element exception flags

Behaviour:
- Reset values:
  - State=IDLE; all counters and regs 0.
  - req_rdy=1; seq_ex1_vld=0; seq_done_vld=0.
  - seq_done_result=0; seq_done_fflags=0; seq_ex1_src=0; seq_ex1_func=0.
- VLMAX = 8/4/2 for sew 16/32/64. Effective vl = min(req_vl, VLMAX).
- States:
  - IDLE: req_rdy=1. On req_vld the block latches src, sew, func and effective vl, and clears result and fflags.
    - vl≠0 → ISSUE.
    - vl=0 → DONE.
  - ISSUE: seq_ex1_vld=1 every cycle. seq_ex1_src = element[iss_cnt] of latched src; iss_cnt increments each cycle.
    - When the element with index vl-1 is issued → DRAIN.
  - DRAIN: seq_ex1_vld=0. Wait for ret_cnt==vl → DONE.
  - DONE: seq_done_vld=1 for exactly one cycle; result and fflags are stable → IDLE.
  - FLUSHW: req_rdy=0 for PIPE_LAT cycles, counted by a down-counter → IDLE.
- req_rdy=0 in every state except IDLE. There is no back-to-back accept in the DONE cycle.
- Returns:
  - Each fcnvt_ex3_vld in ISSUE or DRAIN writes the low sew bits of the result into lane ret_cnt of the result register.
  - It ORs expt into fflags and increments ret_cnt.
  - A return and an issue in the same cycle are both handled.
  - A return in IDLE, DONE or FLUSHW is ignored (no state change).
- Lanes ≥ vl are 0.
- Latency: the first issue is 1 cycle after acceptance. seq_done_vld is asserted PIPE_LAT+1 cycles after the last issue.
  - Example: vl=4, accept at cycle 0 → issues at cycles 1-4, last return at cycle 7, done at cycle 8.
- Flush:
  - Flush in ISSUE, DRAIN or DONE → FLUSHW next cycle. Counters clear, seq_ex1_vld drops the same cycle (combinationally gated), and seq_done_vld is suppressed.
  - Flush in IDLE clears nothing and does not block acceptance.
  - Flush in FLUSHW restarts the window.
  - Flush has priority over req_vld.
- Async reset mid-operation returns the block to IDLE immediately. Outputs take their reset values.

Test Plan:
- sew=1, vl=4, src = four singles, each ex3 result = element+1, expt all 0 → 4 issues on consecutive cycles; seq_done_result = {e3+1,e2+1,e1+1,e0+1}; done 4 cycles after the last issue; fflags=0.
- sew=0, vl=8, expt of element 2 = 5'b00001, expt of element 6 = 5'b00100 → fflags=5'b00101; all 8 half lanes packed in order.
- sew=2, vl=5 → clamped to 2; exactly 2 issues; result bits [127:0] = {r1,r0}.
- vl=0 → no seq_ex1_vld; done pulse 1 cycle after accept; result=0; fflags=0.
- Flush in DRAIN with 2 returns outstanding → no done pulse; req_rdy low for 3 cycles despite the stale returns; the next request completes with correct lanes and no stale flags.
- cpurst_b asserted during ISSUE → seq_ex1_vld=0 immediately; req_rdy=1 after deassertion.
